mux_stream_arb: RTL



---
 rtl/mux_stream_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mux_stream_arb.sv
// Registered N-way stream selector. Picks one producer per cycle, either by an
// explicit select (MODE 0) or by round-robin arbitration (MODE 1), and loads the
// chosen word into a single output pipeline register with a valid/ready handshake.
module mux_stream_arb #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CHANNELS  = 16,
  parameter int unsigned SEL_WIDTH = 4,
  parameter int unsigned MODE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_WIDTH-1:0]      s,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       d_valid,
  output logic [CHANNELS-1:0]       d_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SEL_WIDTH-1:0]      y_sel,
  output logic                      sel_err
);

  // One extra bit so CHANNELS itself and pointer+offset sums are representable.
  localparam logic [SEL_WIDTH:0]   ChanCnt = (SEL_WIDTH + 1)'(CHANNELS);
  localparam logic [SEL_WIDTH-1:0] LastCh  = SEL_WIDTH'(CHANNELS - 1);

  logic [WIDTH-1:0]     y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic [SEL_WIDTH-1:0] y_sel_q, y_sel_d;
  logic                 sel_err_q, sel_err_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  logic                 accept;
  logic                 grant;
  logic                 sel_bad;
  logic [SEL_WIDTH-1:0] g;
  logic [SEL_WIDTH:0]   idx_w;
  logic [WIDTH-1:0]     gdata;

  // Grant decision: explicit select with range check, or circular scan after rr_ptr.
  always_comb begin
    grant   = 1'b0;
    g       = '0;
    sel_bad = 1'b0;
    idx_w   = '0;
    if (MODE == 0) begin
      if ({1'b0, s} < ChanCnt) begin
        g     = s;
        grant = d_valid[s];
      end else begin
        sel_bad = 1'b1;
      end
    end else begin
      // Offsets 1..CHANNELS visit every channel once, ending on rr_ptr itself.
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        idx_w = {1'b0, rr_ptr_q} + (SEL_WIDTH + 1)'(k);
        if (idx_w >= ChanCnt) begin
          idx_w = idx_w - ChanCnt;
        end
        if (!grant && d_valid[idx_w[SEL_WIDTH-1:0]]) begin
          grant = 1'b1;
          g     = idx_w[SEL_WIDTH-1:0];
        end
      end
    end
  end

  // Handshake: data mux for the granted channel and its one-hot ready.
  always_comb begin
    accept  = !y_valid_q || y_ready;
    d_ready = '0;
    gdata   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (g == SEL_WIDTH'(i)) begin
        gdata      = d[i*WIDTH +: WIDTH];
        d_ready[i] = accept && grant && !rst;
      end
    end
  end

  // Next state: load on a granted accept, drop valid on an ungranted accept, else hold.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    y_sel_d   = y_sel_q;
    rr_ptr_d  = rr_ptr_q;
    sel_err_d = accept && sel_bad;
    if (accept) begin
      y_valid_d = grant;
      if (grant) begin
        y_d     = gdata;
        y_sel_d = g;
        if (MODE != 0) begin
          rr_ptr_d = g;
        end
      end
    end
  end

  // State register; reset parks rr_ptr on the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_sel_q   <= '0;
      sel_err_q <= 1'b0;
      rr_ptr_q  <= LastCh;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      y_sel_q   <= y_sel_d;
      sel_err_q <= sel_err_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign y_sel   = y_sel_q;
  assign sel_err = sel_err_q;

endmodule
